// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file read stage.
package regfile_pkg;
  localparam int REG_WIDTH  = 32;
  localparam int REG_DEPTH  = 32;
  localparam int REG_ADDR_W = $clog2(REG_DEPTH);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]  reg_data_t;

  localparam reg_data_t REG_ZERO = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, with a per-port hazard query.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int depth = REG_DEPTH,
  parameter int addrW = $clog2(depth)
) (
  input  logic             iClk,
  input  logic             nRst,
  input  logic             set_en,
  input  logic [addrW-1:0] set_addr,
  input  logic             clr_en,
  input  logic [addrW-1:0] clr_addr,
  input  logic             flush,
  input  logic [addrW-1:0] rs1,
  input  logic [addrW-1:0] rs2,
  output logic             hazard1,
  output logic             hazard2
);

  logic [depth-1:0] busy;
  logic [depth-1:0] busy_next;

  // Clear is applied before set so a younger pending writer survives an older writeback.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (set_en) busy_next[set_addr] = 1'b1;
    if (flush)  busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) busy <= '0;
    else       busy <= busy_next;
  end

  assign hazard1 = busy[rs1] & (rs1 != '0) & !(clr_en & (clr_addr == rs1));
  assign hazard2 = busy[rs2] & (rs2 != '0) & !(clr_en & (clr_addr == rs2));

endmodule

// File: rtl/reg_read_stage.sv
// Register file read stage: storage, writeback bypass, scoreboard stall and a
// single registered operand slot toward execute.
module reg_read_stage
  import regfile_pkg::*;
#(
  parameter int width = REG_WIDTH,
  parameter int depth = REG_DEPTH,
  parameter int addrW = $clog2(depth)
) (
  input  logic             iClk,
  input  logic             nRst,
  input  logic             iRdValid,
  output logic             oRdReady,
  input  logic [addrW-1:0] iRs1,
  input  logic [addrW-1:0] iRs2,
  input  logic             iDstEn,
  input  logic [addrW-1:0] iDst,
  output logic             oOpValid,
  input  logic             iOpReady,
  output logic [width-1:0] oOp1,
  output logic [width-1:0] oOp2,
  input  logic             iWbEn,
  input  logic [addrW-1:0] iWbAddr,
  input  logic [width-1:0] iWbData,
  input  logic             iFlush
);

  logic [width-1:0] regs [depth];
  logic             hazard1;
  logic             hazard2;
  logic             accept;
  logic             wb_write;
  logic             set_en;
  logic [width-1:0] op1_sel;
  logic [width-1:0] op2_sel;

  function automatic logic [width-1:0] pick_operand(
    input logic [addrW-1:0] rs,
    input logic             wb_en,
    input logic [addrW-1:0] wb_addr,
    input logic [width-1:0] wb_data,
    input logic [width-1:0] stored
  );
    if (rs == '0)                    return width'(REG_ZERO);
    else if (wb_en && wb_addr == rs) return wb_data;
    else                             return stored;
  endfunction

  assign wb_write = iWbEn & (iWbAddr != '0);
  assign oRdReady = !iFlush & !hazard1 & !hazard2 & (!oOpValid | iOpReady);
  assign accept   = iRdValid & oRdReady;
  assign set_en   = accept & iDstEn & (iDst != '0);

  reg_scoreboard #(
    .depth (depth),
    .addrW (addrW)
  ) u_scoreboard (
    .iClk     (iClk),
    .nRst     (nRst),
    .set_en   (set_en),
    .set_addr (iDst),
    .clr_en   (wb_write),
    .clr_addr (iWbAddr),
    .flush    (iFlush),
    .rs1      (iRs1),
    .rs2      (iRs2),
    .hazard1  (hazard1),
    .hazard2  (hazard2)
  );

  always_comb begin
    op1_sel = pick_operand(iRs1, iWbEn, iWbAddr, iWbData, regs[iRs1]);
    op2_sel = pick_operand(iRs2, iWbEn, iWbAddr, iWbData, regs[iRs2]);
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < depth; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[iWbAddr] <= iWbData;
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oOpValid <= 1'b0;
      oOp1     <= '0;
      oOp2     <= '0;
    end else if (iFlush) begin
      oOpValid <= 1'b0;
    end else if (accept) begin
      oOpValid <= 1'b1;
      oOp1     <= op1_sel;
      oOp2     <= op2_sel;
    end else if (iOpReady) begin
      oOpValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: reset, bypass, hazard stall, x0, backpressure, flush.
module tb_reg_read_stage;
  import regfile_pkg::*;

  logic      iClk = 1'b0;
  logic      nRst;
  logic      iRdValid, iDstEn, iOpReady, iWbEn, iFlush;
  reg_addr_t iRs1, iRs2, iDst, iWbAddr;
  reg_data_t iWbData;
  logic      oRdReady, oOpValid;
  reg_data_t oOp1, oOp2;

  int total = 0;
  int bad   = 0;

  reg_read_stage dut (
    .iClk     (iClk),
    .nRst     (nRst),
    .iRdValid (iRdValid),
    .oRdReady (oRdReady),
    .iRs1     (iRs1),
    .iRs2     (iRs2),
    .iDstEn   (iDstEn),
    .iDst     (iDst),
    .oOpValid (oOpValid),
    .iOpReady (iOpReady),
    .oOp1     (oOp1),
    .oOp2     (oOp2),
    .iWbEn    (iWbEn),
    .iWbAddr  (iWbAddr),
    .iWbData  (iWbData),
    .iFlush   (iFlush)
  );

  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    iRdValid = 0; iDstEn = 0; iDst = 0; iRs1 = 0; iRs2 = 0;
    iWbEn = 0; iWbAddr = 0; iWbData = 0; iFlush = 0; iOpReady = 1;
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic req(input reg_addr_t r1, input reg_addr_t r2, input logic den, input reg_addr_t d);
    iRdValid = 1; iRs1 = r1; iRs2 = r2; iDstEn = den; iDst = d;
  endtask

  task automatic wb(input reg_addr_t a, input reg_data_t v);
    iWbEn = 1; iWbAddr = a; iWbData = v;
  endtask

  task automatic test_reset();
    idle();
    nRst = 0;
    #12;
    total++; if (oOpValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", oOpValid); end
    total++; if (oOp1 !== 32'h0) begin bad++; $display("FAIL reset_op1: got %h want 0", oOp1); end
    total++; if (oOp2 !== 32'h0) begin bad++; $display("FAIL reset_op2: got %h want 0", oOp2); end
    total++; if (oRdReady !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", oRdReady); end
    nRst = 1;
    tick();
  endtask

  task automatic test_basic_read();
    req(1, 2, 0, 0);
    #1;
    total++; if (oRdReady !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b want 1", oRdReady); end
    tick();
    total++; if (oOpValid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", oOpValid); end
    total++; if (oOp1 !== 32'h0 || oOp2 !== 32'h0) begin bad++; $display("FAIL basic_ops: got %h %h want 0 0", oOp1, oOp2); end
    idle();
    tick();
    total++; if (oOpValid !== 1'b0) begin bad++; $display("FAIL basic_drain: got %b want 0", oOpValid); end
  endtask

  task automatic test_bypass();
    wb(5, 32'hDEADBEEF);
    req(5, 0, 0, 0);
    #1;
    total++; if (oRdReady !== 1'b1) begin bad++; $display("FAIL bypass_ready: got %b want 1", oRdReady); end
    tick();
    total++; if (oOp1 !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_op1: got %h want deadbeef", oOp1); end
    idle();
    req(0, 5, 0, 0);
    tick();
    total++; if (oOp2 !== 32'hDEADBEEF || oOp1 !== 32'h0) begin bad++; $display("FAIL stored_read: got %h %h want 0 deadbeef", oOp1, oOp2); end
    idle();
    tick();
  endtask

  task automatic test_hazard();
    req(0, 0, 1, 7);
    tick();
    idle();
    req(1, 7, 0, 0);
    #1;
    total++; if (oRdReady !== 1'b0) begin bad++; $display("FAIL hazard_stall0: got %b want 0", oRdReady); end
    tick();
    total++; if (oRdReady !== 1'b0) begin bad++; $display("FAIL hazard_stall1: got %b want 0", oRdReady); end
    total++; if (oOpValid !== 1'b0) begin bad++; $display("FAIL hazard_novalid: got %b want 0", oOpValid); end
    wb(7, 32'h1234);
    #1;
    total++; if (oRdReady !== 1'b1) begin bad++; $display("FAIL hazard_release: got %b want 1", oRdReady); end
    tick();
    total++; if (oOpValid !== 1'b1 || oOp2 !== 32'h1234) begin bad++; $display("FAIL hazard_op2: got %b %h want 1 1234", oOpValid, oOp2); end
    // same-edge set of x3 and writeback of x3: busy must stay set
    idle();
    req(0, 0, 1, 3);
    wb(3, 32'h33);
    tick();
    idle();
    req(3, 0, 0, 0);
    #1;
    total++; if (oRdReady !== 1'b0) begin bad++; $display("FAIL set_wins: got %b want 0", oRdReady); end
    wb(3, 32'h44);
    tick();
    total++; if (oOp1 !== 32'h44) begin bad++; $display("FAIL set_wins_op1: got %h want 44", oOp1); end
    idle();
    req(4, 0, 1, 4);
    #1;
    total++; if (oRdReady !== 1'b1) begin bad++; $display("FAIL no_self_stall: got %b want 1", oRdReady); end
    tick();
    idle();
    req(4, 0, 0, 0);
    #1;
    total++; if (oRdReady !== 1'b0) begin bad++; $display("FAIL self_busy: got %b want 0", oRdReady); end
    idle();
    wb(4, 32'h40);
    tick();
    idle();
  endtask

  task automatic test_x0();
    wb(0, 32'hFFFFFFFF);
    tick();
    idle();
    req(0, 0, 1, 0);
    wb(0, 32'hFFFFFFFF);
    #1;
    total++; if (oRdReady !== 1'b1) begin bad++; $display("FAIL x0_ready: got %b want 1", oRdReady); end
    tick();
    total++; if (oOp1 !== 32'h0) begin bad++; $display("FAIL x0_op1: got %h want 0", oOp1); end
    idle();
    req(0, 0, 0, 0);
    #1;
    total++; if (oRdReady !== 1'b1) begin bad++; $display("FAIL x0_nostall: got %b want 1", oRdReady); end
    tick();
    total++; if (oOp1 !== 32'h0 || oOp2 !== 32'h0) begin bad++; $display("FAIL x0_ops: got %h %h want 0 0", oOp1, oOp2); end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    req(5, 7, 0, 0);
    iOpReady = 0;
    tick();
    req(7, 5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (oRdReady !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, oRdReady); end
      total++; if (oOpValid !== 1'b1 || oOp1 !== 32'hDEADBEEF || oOp2 !== 32'h1234) begin bad++; $display("FAIL bp_hold[%0d]: got %b %h %h want 1 deadbeef 1234", i, oOpValid, oOp1, oOp2); end
      tick();
    end
    iOpReady = 1;
    #1;
    total++; if (oRdReady !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", oRdReady); end
    tick();
    total++; if (oOp1 !== 32'h1234 || oOp2 !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_queued: got %h %h want 1234 deadbeef", oOp1, oOp2); end
  endtask

  task automatic test_back_to_back();
    reg_addr_t r1 [3] = '{5, 7, 3};
    reg_addr_t r2 [3] = '{0, 5, 7};
    reg_data_t e1 [3] = '{32'hDEADBEEF, 32'h1234, 32'h44};
    reg_data_t e2 [3] = '{32'h0, 32'hDEADBEEF, 32'h1234};
    for (int i = 0; i < 3; i++) begin
      req(r1[i], r2[i], 0, 0);
      #1;
      total++; if (oRdReady !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, oRdReady); end
      tick();
      total++; if (oOpValid !== 1'b1 || oOp1 !== e1[i] || oOp2 !== e2[i]) begin bad++; $display("FAIL b2b_ops[%0d]: got %b %h %h want 1 %h %h", i, oOpValid, oOp1, oOp2, e1[i], e2[i]); end
    end
    idle();
    tick();
  endtask

  task automatic test_flush_reset();
    req(0, 0, 1, 9);
    tick();
    total++; if (oOpValid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid: got %b want 1", oOpValid); end
    req(9, 0, 0, 0);
    #1;
    total++; if (oRdReady !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", oRdReady); end
    iFlush = 1;
    iOpReady = 0;
    wb(10, 32'hCAFE);
    #1;
    total++; if (oRdReady !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", oRdReady); end
    tick();
    total++; if (oOpValid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", oOpValid); end
    idle();
    req(9, 10, 0, 0);
    #1;
    total++; if (oRdReady !== 1'b1) begin bad++; $display("FAIL flush_cleared: got %b want 1", oRdReady); end
    tick();
    total++; if (oOp1 !== 32'h0 || oOp2 !== 32'hCAFE) begin bad++; $display("FAIL flush_ops: got %h %h want 0 cafe", oOp1, oOp2); end
    req(5, 0, 1, 11);
    tick();
    total++; if (oOpValid !== 1'b1 || oOp1 !== 32'hDEADBEEF) begin bad++; $display("FAIL rst_pre: got %b %h want 1 deadbeef", oOpValid, oOp1); end
    idle();
    nRst = 0;
    #1;
    total++; if (oOpValid !== 1'b0 || oOp1 !== 32'h0 || oOp2 !== 32'h0) begin bad++; $display("FAIL rst_async: got %b %h %h want 0 0 0", oOpValid, oOp1, oOp2); end
    #1;
    nRst = 1;
    req(5, 11, 0, 0);
    #1;
    total++; if (oRdReady !== 1'b1) begin bad++; $display("FAIL rst_busy_clear: got %b want 1", oRdReady); end
    tick();
    total++; if (oOp1 !== 32'h0 || oOp2 !== 32'h0) begin bad++; $display("FAIL rst_storage: got %h %h want 0 0", oOp1, oOp2); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_bypass();
    test_hazard();
    test_x0();
    test_backpressure();
    test_back_to_back();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
